fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of asynchronous_fifo among NUM_REQ producers in the write-clock domain.
- Drives the FIFO's w_en/data_in and observes its full flag.
- Grants bounded bursts (MAX_BURST beats) and paces writes one per two cycles, so full is always current when a write is decided; overflow is impossible by construction.

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers
//   in the write-clock domain. Grants bursts of up to MAX_BURST beats and
//   issues at most one write every two cycles. The cycle after each write
//   (GAP) has w_en low, so the FIFO's full flag has settled before the next
//   write is decided. Because of this, the FIFO cannot overflow.
//
// Ports
//   wclk, wrst_n : write clock, async active-low reset
//   req_valid    : per-requester request, held with req_data until acked
//   req_data     : requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack      : one-hot beat-accepted pulse, coincident with w_en
//   full         : FIFO full flag (wclk domain)
//   w_en/data_in : registered FIFO write port
//   owner        : index of the current grant holder
//   busy         : grant held (ISSUE or GAP)
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [OW-1:0]                 owner,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam int BW = 8;

    state_t                  state, state_d;
    logic [OW-1:0]           rr_ptr, rr_ptr_d;
    logic [BW-1:0]           beat_cnt, beat_cnt_d;
    logic [NUM_REQ-1:0]      req_ack_d;
    logic                    w_en_d, busy_d;
    logic [DATA_WIDTH-1:0]   data_in_d;
    logic [OW-1:0]           owner_d;

    logic                    win_vld;
    logic [OW-1:0]           win;
    logic [OW-1:0]           owner_nxt;

    // First valid index at or after rr_ptr, scanning cyclically.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [OW:0] j;
            j = {1'b0, rr_ptr} + (OW+1)'(k);
            if (j >= (OW+1)'(NUM_REQ)) j = j - (OW+1)'(NUM_REQ);
            if (!win_vld && req_valid[j]) begin
                win_vld = 1'b1;
                win     = j[OW-1:0];
            end
        end
    end

    // The requester after the releasing owner gets top priority next round.
    assign owner_nxt = (owner == OW'(NUM_REQ-1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_d    = state;
        w_en_d     = 1'b0;
        req_ack_d  = '0;
        data_in_d  = '0;
        owner_d    = owner;
        busy_d     = busy;
        rr_ptr_d   = rr_ptr;
        beat_cnt_d = beat_cnt;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (win_vld && !full) begin
                    data_in_d      = req_data[win*DATA_WIDTH +: DATA_WIDTH];
                    w_en_d         = 1'b1;
                    req_ack_d[win] = 1'b1;
                    owner_d        = win;
                    beat_cnt_d     = BW'(1);
                    busy_d         = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = GAP;
            end
            GAP: begin
                // full here already reflects the write closed by ISSUE.
                if (req_valid[owner] && beat_cnt < BW'(MAX_BURST) && !full) begin
                    data_in_d        = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
                    w_en_d           = 1'b1;
                    req_ack_d[owner] = 1'b1;
                    beat_cnt_d       = beat_cnt + 1'b1;
                    state_d          = ISSUE;
                end else begin
                    rr_ptr_d = owner_nxt;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            w_en     <= 1'b0;
            data_in  <= '0;
            req_ack  <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            w_en     <= w_en_d;
            data_in  <= data_in_d;
            req_ack  <= req_ack_d;
            owner    <= owner_d;
            busy     <= busy_d;
            rr_ptr   <= rr_ptr_d;
            beat_cnt <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round-robin
// ordering, full back-pressure, reset mid-burst, and a FIFO-model stream.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int OW    = 2;
    localparam int DEPTH = 8;

    logic               wclk = 1'b0;
    logic               wrst_n = 1'b0;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ack;
    logic               full;
    logic               w_en;
    logic [DW-1:0]      data_in;
    logic [OW-1:0]      owner;
    logic               busy;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .full(full), .w_en(w_en), .data_in(data_in),
        .owner(owner), .busy(busy)
    );

    always #5 wclk = ~wclk;

    // Requester model: word list per requester, advanced on each ack.
    logic [DW-1:0] words [NR][128];
    logic [7:0]    ptr   [NR];
    logic [7:0]    len   [NR];
    logic [NR-1:0] en = '0;

    initial for (int i = 0; i < NR; i++) begin ptr[i] = 8'd0; len[i] = 8'd0; end

    for (genvar g = 0; g < NR; g++) begin : g_req
        assign req_valid[g]          = en[g] && (ptr[g] < len[g]);
        assign req_data[g*DW +: DW]  = words[g][ptr[g][6:0]];
    end

    always @(posedge wclk)
        for (int i = 0; i < NR; i++)
            if (req_ack[i]) ptr[i] <= ptr[i] + 8'd1;

    // Simple FIFO occupancy model with a slow reader.
    logic fifo_mode = 1'b0;
    logic full_force = 1'b0;
    int   fcnt = 0, rd_cnt = 0, viol = 0, cyc = 0;
    logic pop;
    assign pop  = fifo_mode && (cyc % 4 == 0) && (fcnt != 0);
    assign full = fifo_mode ? (fcnt == DEPTH) : full_force;

    always @(posedge wclk) begin
        cyc <= cyc + 1;
        if (fifo_mode) begin
            fcnt <= fcnt + (w_en ? 1 : 0) - (pop ? 1 : 0);
            if (pop) rd_cnt <= rd_cnt + 1;
            if (w_en && fcnt == DEPTH) viol <= viol + 1;
        end
    end

    // Write monitor.
    logic [DW-1:0] log_data [$];
    int            log_own  [$];
    int            log_cyc  [$];
    int            ack_bad = 0;

    always @(negedge wclk) begin
        if (w_en) begin
            log_data.push_back(data_in);
            log_own.push_back(int'(owner));
            log_cyc.push_back(cyc);
            if (req_ack != (NR'(1) << owner)) ack_bad <= ack_bad + 1;
        end else if (req_ack != '0) begin
            ack_bad <= ack_bad + 1;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_wen(input string tag);
        int n = 0;
        do begin @(negedge wclk); n++; end while (!w_en && n < 50);
        chk(tag, {31'd0, w_en}, 32'd1);
    endtask

    task automatic wait_log(input string tag, input int target, input int budget);
        int n = 0;
        while (log_data.size() < target && n < budget) begin @(negedge wclk); n++; end
        chk(tag, log_data.size(), target);
    endtask

    task automatic load(input int r, input int n, input int seed);
        for (int k = 0; k < n; k++) words[r][ptr[r] + k] = DW'(seed + k);
        len[r] = ptr[r] + 8'(n);
    endtask

    int L;
    int exp_own3 [20] = '{1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1,2,3,0};
    int seen [NR];
    int base [NR];
    int o;

    initial begin
        // 1: reset with inputs toggling
        en = '1;
        for (int i = 0; i < NR; i++) load(i, 1, 8'hE0 + i);
        for (int c = 0; c < 3; c++) begin
            full_force = c[0];
            @(negedge wclk);
            chk("rst_wen", {31'd0, w_en}, 32'd0);
            chk("rst_ack", {28'd0, req_ack}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_data", {24'd0, data_in}, 32'd0);
        end
        en = '0;
        full_force = 1'b0;
        wrst_n = 1'b1;
        repeat (4) @(negedge wclk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_nowr", log_data.size(), 0);

        // 2: single requester, 5 words, burst of 4 then re-grant
        for (int i = 0; i < NR; i++) len[i] = ptr[i];
        L = log_data.size();
        load(0, 5, 8'h11);
        for (int k = 0; k < 5; k++) words[0][ptr[0] + k] = DW'(8'h11 * (k + 1));
        en[0] = 1'b1;
        wait_log("b_cnt", L + 5, 60);
        for (int k = 0; k < 5; k++) begin
            chk("b_data", {24'd0, log_data[L+k]}, 32'h11 * (k + 1));
            chk("b_own", log_own[L+k], 0);
        end
        for (int k = 1; k < 5; k++)
            chk("b_gap", log_cyc[L+k] - log_cyc[L+k-1], (k == 4) ? 3 : 2);
        repeat (4) @(negedge wclk);

        // 3: all requesters valid, rr_ptr starts at 1 after req0 released
        L = log_data.size();
        for (int i = 0; i < NR; i++) begin
            load(i, 5, 0);
            for (int k = 0; k < 5; k++) words[i][ptr[i] + k] = DW'((i << 4) | k);
            seen[i] = 0;
        end
        en = '1;
        wait_log("rr_cnt", L + 20, 200);
        for (int k = 0; k < 20; k++) begin
            chk("rr_own", log_own[L+k], exp_own3[k]);
            o = exp_own3[k];
            chk("rr_data", {24'd0, log_data[L+k]}, (o << 4) | seen[o]);
            seen[o]++;
        end
        repeat (4) @(negedge wclk);

        // 4: full rises in GAP of req1's burst
        L = log_data.size();
        load(1, 4, 8'h50);
        load(2, 2, 8'h60);
        wait_wen("fb_first");
        @(negedge wclk);
        full_force = 1'b1;
        repeat (6) @(negedge wclk);
        chk("fb_hold", log_data.size(), L + 1);
        chk("fb_rel", {31'd0, busy}, 32'd0);
        full_force = 1'b0;
        wait_log("fb_cnt", L + 6, 80);
        begin
            int ed [6] = '{'h50, 'h60, 'h61, 'h51, 'h52, 'h53};
            int eo [6] = '{1, 2, 2, 1, 1, 1};
            for (int k = 0; k < 6; k++) begin
                chk("fb_data", {24'd0, log_data[L+k]}, ed[k]);
                chk("fb_own", log_own[L+k], eo[k]);
            end
        end
        repeat (4) @(negedge wclk);

        // 5: reset during GAP of req3
        L = log_data.size();
        load(3, 3, 8'h70);
        wait_wen("mr_first");
        @(negedge wclk);
        wrst_n = 1'b0;
        load(0, 2, 8'h80);
        #1;
        chk("mr_wen", {31'd0, w_en}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_own", {30'd0, owner}, 32'd0);
        chk("mr_ack", {28'd0, req_ack}, 32'd0);
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        wait_log("mr_cnt", L + 5, 80);
        begin
            int ed [5] = '{'h70, 'h80, 'h81, 'h71, 'h72};
            int eo [5] = '{3, 0, 0, 3, 3};
            for (int k = 0; k < 5; k++) begin
                chk("mr_data", {24'd0, log_data[L+k]}, ed[k]);
                chk("mr_own", log_own[L+k], eo[k]);
            end
        end
        repeat (4) @(negedge wclk);

        // 6: three random producers into the FIFO model
        L = log_data.size();
        en = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            base[i] = int'(ptr[i]);
            seen[i] = 0;
            for (int k = 0; k < 60; k++) words[i][base[i] + k] = DW'($urandom);
            len[i] = ptr[i] + 8'd60;
        end
        fifo_mode = 1'b1;
        begin
            int n = 0;
            while (rd_cnt < 180 && n < 5000) begin @(negedge wclk); n++; end
        end
        chk("e2e_rd", rd_cnt, 180);
        chk("e2e_wr", log_data.size(), L + 180);
        chk("e2e_ovf", viol, 0);
        for (int j = L; j < log_data.size(); j++) begin
            o = log_own[j];
            if (o < 3 && seen[o] < 60) begin
                chk("e2e_data", {24'd0, log_data[j]}, {24'd0, words[o][base[o] + seen[o]]});
                seen[o]++;
            end else begin
                chk("e2e_own", o, 0);
            end
        end
        for (int i = 0; i < 3; i++) chk("e2e_per", seen[i], 60);

        chk("ack_onehot", ack_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
